// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-bus arbiter: arbitration modes, FSM states and
// the granted-index width helper.
package mem_arbiter_pkg;

  typedef enum logic {
    ARB_ROUND_ROBIN = 1'b0,
    ARB_FIXED       = 1'b1
  } arb_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // A single-bit index is kept even for two ports so the port-id bus never collapses.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_picker.sv
// Combinational winner selection over an eligible mask, either round-robin
// starting after last_grant or fixed priority with index 0 highest.
module mem_arbiter_picker
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter arb_mode_t   ARB_MODE  = ARB_ROUND_ROBIN,
  parameter int unsigned ID_WIDTH  = id_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [ID_WIDTH-1:0]  last_grant,
  output logic                 any_grant,
  output logic [ID_WIDTH-1:0]  grant_id
);

  logic [ID_WIDTH-1:0] cand;

  always_comb begin
    any_grant = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (ARB_MODE == ARB_FIXED) begin
        cand = ID_WIDTH'(k);
      end else begin
        cand = ID_WIDTH'((32'(last_grant) + k + 32'd1) % NUM_PORTS);
      end
      if (!any_grant && eligible[cand]) begin
        any_grant = 1'b1;
        grant_id  = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter sharing one memory bus: IDLE arbitrates and latches the winner's
// request onto registered mem_* outputs, BUSY waits for mem_valid and pulses port_valid.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter arb_mode_t   ARB_MODE   = ARB_ROUND_ROBIN,
  parameter int unsigned ID_WIDTH   = id_width(NUM_PORTS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_PORTS-1:0]                  port_ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]       port_wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   port_wstrb,
  output logic [NUM_PORTS-1:0]                  port_valid,
  output logic [DATA_WIDTH-1:0]                 port_rdata,
  output logic                                  mem_ready,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  output logic [DATA_WIDTH/8-1:0]               mem_wstrb,
  input  logic                                  mem_valid,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata,
  output logic [ID_WIDTH-1:0]                   mem_port_id
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  arb_state_t              state_q,       state_d;
  logic [ID_WIDTH-1:0]     last_grant_q,  last_grant_d;
  logic                    mem_ready_q,   mem_ready_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q,    mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q,   mem_wdata_d;
  logic [STRB_WIDTH-1:0]   mem_wstrb_q,   mem_wstrb_d;
  logic [ID_WIDTH-1:0]     mem_port_id_q, mem_port_id_d;
  logic [NUM_PORTS-1:0]    port_valid_q,  port_valid_d;
  logic [DATA_WIDTH-1:0]   port_rdata_q,  port_rdata_d;

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_PORTS];
  logic [STRB_WIDTH-1:0]   wstrb_arr [NUM_PORTS];

  logic [NUM_PORTS-1:0]    eligible;
  logic                    any_grant;
  logic [ID_WIDTH-1:0]     grant_id;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      addr_arr[i]  = port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      wstrb_arr[i] = port_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
    end
  end

  // A port whose completion pulse is on the wire this cycle must not be re-granted.
  assign eligible = port_ready & ~port_valid_q;

  mem_arbiter_picker #(
    .NUM_PORTS (NUM_PORTS),
    .ARB_MODE  (ARB_MODE),
    .ID_WIDTH  (ID_WIDTH)
  ) u_picker (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .any_grant  (any_grant),
    .grant_id   (grant_id)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_ready_d   = mem_ready_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    mem_port_id_d = mem_port_id_q;
    port_valid_d  = '0;
    port_rdata_d  = port_rdata_q;

    case (state_q)
      IDLE: begin
        if (any_grant) begin
          mem_addr_d    = addr_arr[grant_id];
          mem_wdata_d   = wdata_arr[grant_id];
          mem_wstrb_d   = wstrb_arr[grant_id];
          mem_port_id_d = grant_id;
          mem_ready_d   = 1'b1;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (mem_valid) begin
          mem_ready_d                 = 1'b0;
          port_rdata_d                = mem_rdata;
          port_valid_d[mem_port_id_q] = 1'b1;
          last_grant_d                = mem_port_id_q;
          state_d                     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= ID_WIDTH'(NUM_PORTS - 1);
      mem_ready_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= '0;
      mem_port_id_q <= '0;
      port_valid_q  <= '0;
      port_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_ready_q   <= mem_ready_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      mem_port_id_q <= mem_port_id_d;
      port_valid_q  <= port_valid_d;
      port_rdata_q  <= port_rdata_d;
    end
  end

  assign port_valid  = port_valid_q;
  assign port_rdata  = port_rdata_q;
  assign mem_ready   = mem_ready_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign mem_port_id = mem_port_id_q;

  // Completion pulses are one-hot and never overlap an outstanding request.
  assert property (@(posedge clk) disable iff (reset)
    $onehot0(port_valid) && !(mem_ready && (|port_valid)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 4-port round-robin and a 4-port fixed-priority
// instance, directed vector table, grant-order sequences, async reset, random vs model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    a_ready,  b_ready;
  logic [NP*AW-1:0] a_addr,   b_addr;
  logic [NP*DW-1:0] a_wdata,  b_wdata;
  logic [NP*SW-1:0] a_wstrb,  b_wstrb;
  logic             a_mvalid, b_mvalid;
  logic [DW-1:0]    a_mrdata, b_mrdata;
  logic [NP-1:0]    a_pvalid, b_pvalid;
  logic [DW-1:0]    a_prdata, b_prdata;
  logic             a_mready, b_mready;
  logic [AW-1:0]    a_maddr,  b_maddr;
  logic [DW-1:0]    a_mwdata, b_mwdata;
  logic [SW-1:0]    a_mwstrb, b_mwstrb;
  logic [1:0]       a_mid,    b_mid;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(ARB_ROUND_ROBIN)) dut_rr (
    .clk(clk), .reset(reset), .port_ready(a_ready), .port_addr(a_addr), .port_wdata(a_wdata),
    .port_wstrb(a_wstrb), .port_valid(a_pvalid), .port_rdata(a_prdata), .mem_ready(a_mready),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_wstrb(a_mwstrb), .mem_valid(a_mvalid),
    .mem_rdata(a_mrdata), .mem_port_id(a_mid));

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .reset(reset), .port_ready(b_ready), .port_addr(b_addr), .port_wdata(b_wdata),
    .port_wstrb(b_wstrb), .port_valid(b_pvalid), .port_rdata(b_prdata), .mem_ready(b_mready),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_wstrb(b_mwstrb), .mem_valid(b_mvalid),
    .mem_rdata(b_mrdata), .mem_port_id(b_mid));

  int unsigned n_pass;
  int unsigned n_total;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: one outstanding transfer, next owner chosen from the request rules.
  typedef struct {
    bit          busy;
    int unsigned owner;
    int unsigned last;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  pvalid;
    logic [31:0] rdata;
  } mstate_t;

  function automatic mstate_t model_reset();
    mstate_t s;
    s.busy = 0; s.owner = 0; s.last = NP - 1;
    s.addr = '0; s.wdata = '0; s.wstrb = '0; s.pvalid = '0; s.rdata = '0;
    return s;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input bit fixed, input logic [3:0] ready,
                                         input logic [127:0] addr, input logic [127:0] wdata,
                                         input logic [15:0] wstrb, input logic mvalid,
                                         input logic [31:0] mrdata);
    mstate_t n;
    int unsigned p;
    n = s;
    n.pvalid = '0;
    if (!s.busy) begin
      for (int unsigned k = 0; k < NP; k++) begin
        p = fixed ? k : (s.last + 1 + k) % NP;
        if (ready[p] && !s.pvalid[p]) begin
          n.busy  = 1;
          n.owner = p;
          n.addr  = addr[p*AW +: AW];
          n.wdata = wdata[p*DW +: DW];
          n.wstrb = wstrb[p*SW +: SW];
          break;
        end
      end
    end else if (mvalid) begin
      n.busy = 0;
      n.pvalid[s.owner] = 1'b1;
      n.rdata = mrdata;
      n.last  = s.owner;
    end
    return n;
  endfunction

  task automatic check_model(input bit on_b, input mstate_t m, input string tag);
    if (on_b) begin
      chk({tag, ".fx.mem_ready"},   128'(b_mready), 128'(m.busy));
      chk({tag, ".fx.mem_port_id"}, 128'(b_mid),    128'(m.owner));
      chk({tag, ".fx.mem_addr"},    128'(b_maddr),  128'(m.addr));
      chk({tag, ".fx.mem_wdata"},   128'(b_mwdata), 128'(m.wdata));
      chk({tag, ".fx.mem_wstrb"},   128'(b_mwstrb), 128'(m.wstrb));
      chk({tag, ".fx.port_valid"},  128'(b_pvalid), 128'(m.pvalid));
      chk({tag, ".fx.port_rdata"},  128'(b_prdata), 128'(m.rdata));
    end else begin
      chk({tag, ".rr.mem_ready"},   128'(a_mready), 128'(m.busy));
      chk({tag, ".rr.mem_port_id"}, 128'(a_mid),    128'(m.owner));
      chk({tag, ".rr.mem_addr"},    128'(a_maddr),  128'(m.addr));
      chk({tag, ".rr.mem_wdata"},   128'(a_mwdata), 128'(m.wdata));
      chk({tag, ".rr.mem_wstrb"},   128'(a_mwstrb), 128'(m.wstrb));
      chk({tag, ".rr.port_valid"},  128'(a_pvalid), 128'(m.pvalid));
      chk({tag, ".rr.port_rdata"},  128'(a_prdata), 128'(m.rdata));
    end
  endtask

  task automatic idle_inputs();
    a_ready = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0; a_mvalid = 1'b0; a_mrdata = '0;
    b_ready = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0; b_mvalid = 1'b0; b_mrdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Runs continuous requests with a one-cycle memory and checks the order of grants.
  task automatic grant_seq(input bit on_b, input logic [3:0] req, input int unsigned n,
                           input logic [15:0] exp, input string name);
    int unsigned got;
    logic prev_rdy, cur_rdy;
    logic [1:0] cur_id;
    got = 0;
    prev_rdy = on_b ? b_mready : a_mready;
    if (on_b) b_ready = req; else a_ready = req;
    for (int unsigned c = 0; c < 64 && got < n; c++) begin
      if (on_b) b_mvalid = b_mready; else a_mvalid = a_mready;
      @(posedge clk); #1;
      cur_rdy = on_b ? b_mready : a_mready;
      cur_id  = on_b ? b_mid : a_mid;
      if (cur_rdy && !prev_rdy) begin
        chk($sformatf("%s.grant%0d", name, got), 128'(cur_id), 128'(exp[2*got +: 2]));
        got++;
      end
      prev_rdy = cur_rdy;
    end
    if (got < n) chk({name, ".timeout"}, 128'(got), 128'(n));
    if (on_b) b_ready = '0; else a_ready = '0;
    for (int unsigned c = 0; c < 16 && (on_b ? b_mready : a_mready); c++) begin
      if (on_b) b_mvalid = 1'b1; else a_mvalid = 1'b1;
      @(posedge clk); #1;
    end
    a_mvalid = 1'b0; b_mvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] next_req(input logic [3:0] cur, input logic [3:0] pv);
    logic [3:0] r;
    r = cur;
    for (int unsigned i = 0; i < NP; i++) begin
      if (!cur[i])                      r[i] = ($urandom_range(0, 3) == 0);
      else if (pv[i])                   r[i] = ($urandom_range(0, 1) == 0);
      else if ($urandom_range(0, 19) == 0) r[i] = 1'b0;
    end
    return r;
  endfunction

  typedef struct {
    int unsigned aport;
    logic [3:0]  ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        mvalid;
    logic [31:0] mrdata;
    logic        e_mready;
    logic [1:0]  e_id;
    logic [3:0]  e_pvalid;
    logic [31:0] e_prdata;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [3:0]  e_mwstrb;
  } vec_t;

  localparam int unsigned NROWS = 19;
  vec_t tbl [NROWS];
  mstate_t ma, mb;
  logic [15:0] exp_ids;

  initial begin
    n_pass = 0;
    n_total = 0;
    idle_inputs();
    reset = 1'b1;

    // Reset and idle behaviour, including a stray mem_valid while idle.
    repeat (3) @(posedge clk);
    #1;
    check_model(0, model_reset(), "reset");
    check_model(1, model_reset(), "reset");
    reset = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      a_mvalid = (i == 5);
      b_mvalid = (i == 5);
      @(posedge clk); #1;
      chk($sformatf("idle%0d.rr.mem_ready", i), 128'(a_mready), 128'(0));
      chk($sformatf("idle%0d.rr.port_valid", i), 128'(a_pvalid), 128'(0));
      chk($sformatf("idle%0d.fx.port_valid", i), 128'(b_pvalid), 128'(0));
    end
    a_mvalid = 1'b0; b_mvalid = 1'b0;

    // aport, ready, addr, wdata, wstrb, mvalid, mrdata | mready, id, pvalid, prdata, maddr, mwdata, mwstrb
    tbl[0]  = '{1, 4'b0010, 32'h1000, 32'h0, 4'h0, 1'b0, 32'h0,         1'b1, 2'd1, 4'b0000, 32'h0,         32'h1000, 32'h0,         4'h0};
    tbl[1]  = '{1, 4'b0010, 32'h1000, 32'h0, 4'h0, 1'b0, 32'h0,         1'b1, 2'd1, 4'b0000, 32'h0,         32'h1000, 32'h0,         4'h0};
    tbl[2]  = '{1, 4'b0010, 32'h1000, 32'h0, 4'h0, 1'b0, 32'h0,         1'b1, 2'd1, 4'b0000, 32'h0,         32'h1000, 32'h0,         4'h0};
    tbl[3]  = '{1, 4'b0010, 32'h1000, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'd1, 4'b0010, 32'hDEAD_BEEF, 32'h1000, 32'h0,         4'h0};
    tbl[4]  = '{1, 4'b0000, 32'h1000, 32'h0, 4'h0, 1'b0, 32'h0,         1'b0, 2'd1, 4'b0000, 32'hDEAD_BEEF, 32'h1000, 32'h0,         4'h0};
    tbl[5]  = '{0, 4'b0001, 32'h10, 32'h1234_5678, 4'b0011, 1'b0, 32'h0,         1'b1, 2'd0, 4'b0000, 32'hDEAD_BEEF, 32'h10, 32'h1234_5678, 4'b0011};
    tbl[6]  = '{0, 4'b0001, 32'h10, 32'h1234_5678, 4'b0011, 1'b1, 32'hCAFE_0001, 1'b0, 2'd0, 4'b0001, 32'hCAFE_0001, 32'h10, 32'h1234_5678, 4'b0011};
    tbl[7]  = '{0, 4'b0001, 32'h10, 32'h1234_5678, 4'b0011, 1'b0, 32'h0,         1'b0, 2'd0, 4'b0000, 32'hCAFE_0001, 32'h10, 32'h1234_5678, 4'b0011};
    tbl[8]  = '{0, 4'b0001, 32'h10, 32'h1234_5678, 4'b0011, 1'b0, 32'h0,         1'b1, 2'd0, 4'b0000, 32'hCAFE_0001, 32'h10, 32'h1234_5678, 4'b0011};
    tbl[9]  = '{0, 4'b0000, 32'h10, 32'h1234_5678, 4'b0011, 1'b1, 32'h5555_AAAA, 1'b0, 2'd0, 4'b0001, 32'h5555_AAAA, 32'h10, 32'h1234_5678, 4'b0011};
    tbl[10] = '{0, 4'b0000, 32'h10, 32'h1234_5678, 4'b0011, 1'b1, 32'h7777_7777, 1'b0, 2'd0, 4'b0000, 32'h5555_AAAA, 32'h10, 32'h1234_5678, 4'b0011};
    tbl[11] = '{2, 4'b0100, 32'h2000, 32'h0, 4'h0, 1'b0, 32'h0,         1'b1, 2'd2, 4'b0000, 32'h5555_AAAA, 32'h2000, 32'h0,         4'h0};
    tbl[12] = '{2, 4'b1100, 32'h2000, 32'h0, 4'h0, 1'b0, 32'h0,         1'b1, 2'd2, 4'b0000, 32'h5555_AAAA, 32'h2000, 32'h0,         4'h0};
    tbl[13] = '{2, 4'b0100, 32'h2000, 32'h0, 4'h0, 1'b1, 32'h0BAD_F00D, 1'b0, 2'd2, 4'b0100, 32'h0BAD_F00D, 32'h2000, 32'h0,         4'h0};
    tbl[14] = '{2, 4'b0000, 32'h2000, 32'h0, 4'h0, 1'b0, 32'h0,         1'b0, 2'd2, 4'b0000, 32'h0BAD_F00D, 32'h2000, 32'h0,         4'h0};
    tbl[15] = '{3, 4'b1001, 32'h3000, 32'hA5A5_A5A5, 4'b1111, 1'b0, 32'h0,         1'b1, 2'd3, 4'b0000, 32'h0BAD_F00D, 32'h3000, 32'hA5A5_A5A5, 4'b1111};
    tbl[16] = '{3, 4'b1001, 32'h3000, 32'hA5A5_A5A5, 4'b1111, 1'b1, 32'h3333_3333, 1'b0, 2'd3, 4'b1000, 32'h3333_3333, 32'h3000, 32'hA5A5_A5A5, 4'b1111};
    tbl[17] = '{0, 4'b0001, 32'h40, 32'h0, 4'b0100, 1'b0, 32'h0,         1'b1, 2'd0, 4'b0000, 32'h3333_3333, 32'h40, 32'h0, 4'b0100};
    tbl[18] = '{0, 4'b0001, 32'h40, 32'h0, 4'b0100, 1'b1, 32'h0000_0044, 1'b0, 2'd0, 4'b0001, 32'h0000_0044, 32'h40, 32'h0, 4'b0100};

    for (int unsigned i = 0; i < NROWS; i++) begin
      for (int unsigned p = 0; p < NP; p++) begin
        a_addr[p*AW +: AW]  = (p == tbl[i].aport) ? tbl[i].addr  : 32'hBAD0_0000 + p;
        a_wdata[p*DW +: DW] = (p == tbl[i].aport) ? tbl[i].wdata : 32'hBAD1_0000 + p;
        a_wstrb[p*SW +: SW] = (p == tbl[i].aport) ? tbl[i].wstrb : 4'b1010;
      end
      a_ready  = tbl[i].ready;
      a_mvalid = tbl[i].mvalid;
      a_mrdata = tbl[i].mrdata;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.mem_ready", i),   128'(a_mready), 128'(tbl[i].e_mready));
      chk($sformatf("tbl%0d.mem_port_id", i), 128'(a_mid),    128'(tbl[i].e_id));
      chk($sformatf("tbl%0d.port_valid", i),  128'(a_pvalid), 128'(tbl[i].e_pvalid));
      chk($sformatf("tbl%0d.port_rdata", i),  128'(a_prdata), 128'(tbl[i].e_prdata));
      chk($sformatf("tbl%0d.mem_addr", i),    128'(a_maddr),  128'(tbl[i].e_maddr));
      chk($sformatf("tbl%0d.mem_wdata", i),   128'(a_mwdata), 128'(tbl[i].e_mwdata));
      chk($sformatf("tbl%0d.mem_wstrb", i),   128'(a_mwstrb), 128'(tbl[i].e_mwstrb));
    end
    idle_inputs();
    @(posedge clk); #1;

    // Round-robin fairness from reset: 0,1,2,3,0,1,2,3.
    do_reset();
    exp_ids = '0;
    for (int unsigned j = 0; j < 8; j++) exp_ids[2*j +: 2] = 2'(j % 4);
    grant_seq(0, 4'b1111, 8, exp_ids, "rr_fair");

    // Fixed priority: the just-completed port is masked for one cycle, so the
    // next-lowest requester gets that slot; port 2 starves behind 0 and 1.
    exp_ids = '0;
    for (int unsigned j = 0; j < 6; j++) exp_ids[2*j +: 2] = 2'(j % 2);
    grant_seq(1, 4'b0111, 6, exp_ids, "fx_012");
    exp_ids = '0;
    for (int unsigned j = 0; j < 6; j++) exp_ids[2*j +: 2] = 2'((j % 2) * 2);
    grant_seq(1, 4'b0101, 6, exp_ids, "fx_02");

    // Asynchronous reset while a completion pulse is out, and while BUSY.
    do_reset();
    a_ready = 4'b0100;
    @(posedge clk); #1;
    chk("ar.busy.mem_ready", 128'(a_mready), 128'(1));
    a_ready = 4'b0000; a_mvalid = 1'b1; a_mrdata = 32'h0000_0099;
    @(posedge clk); #1;
    chk("ar.port_valid", 128'(a_pvalid), 128'(4'b0100));
    a_mvalid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("ar.pv_async.port_valid", 128'(a_pvalid), 128'(0));
    chk("ar.pv_async.port_rdata", 128'(a_prdata), 128'(0));
    #2 reset = 1'b0;
    a_ready = 4'b0100;
    @(posedge clk); #1;
    a_ready = 4'b0000; a_mvalid = 1'b1;
    @(posedge clk); #1;
    a_ready = 4'b0010; a_mvalid = 1'b0;
    @(posedge clk); #1;
    chk("ar.regrant.mem_port_id", 128'(a_mid), 128'(1));
    chk("ar.regrant.mem_ready", 128'(a_mready), 128'(1));
    #3 reset = 1'b1;
    #1;
    chk("ar.busy_async.mem_ready", 128'(a_mready), 128'(0));
    chk("ar.busy_async.mem_port_id", 128'(a_mid), 128'(0));
    chk("ar.busy_async.mem_addr", 128'(a_maddr), 128'(0));
    #2 reset = 1'b0;
    a_ready = 4'b1111;
    @(posedge clk); #1;
    chk("ar.first.mem_port_id", 128'(a_mid), 128'(0));
    chk("ar.first.mem_ready", 128'(a_mready), 128'(1));
    a_ready = 4'b0000; a_mvalid = 1'b1;
    @(posedge clk); #1;
    a_mvalid = 1'b0;

    // Random traffic on both instances against the reference model.
    do_reset();
    ma = model_reset();
    mb = model_reset();
    for (int unsigned cyc = 0; cyc < 1500; cyc++) begin
      a_ready  = next_req(a_ready, a_pvalid);
      b_ready  = next_req(b_ready, b_pvalid);
      a_addr   = {$urandom, $urandom, $urandom, $urandom};
      b_addr   = {$urandom, $urandom, $urandom, $urandom};
      a_wdata  = {$urandom, $urandom, $urandom, $urandom};
      b_wdata  = {$urandom, $urandom, $urandom, $urandom};
      a_wstrb  = 16'($urandom);
      b_wstrb  = 16'($urandom);
      a_mvalid = a_mready ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      b_mvalid = b_mready ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      a_mrdata = $urandom;
      b_mrdata = $urandom;
      ma = model_step(ma, 1'b0, a_ready, a_addr, a_wdata, a_wstrb, a_mvalid, a_mrdata);
      mb = model_step(mb, 1'b1, b_ready, b_addr, b_wdata, b_wstrb, b_mvalid, b_mrdata);
      @(posedge clk); #1;
      check_model(0, ma, $sformatf("rnd%0d", cyc));
      check_model(1, mb, $sformatf("rnd%0d", cyc));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
